// File: rtl/npc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : npc_ctrl
//  Description : Multi-cycle sequencer for the NPC core. Fetches one
//                instruction at a time over a req/valid instruction port,
//                decodes ADDI (executed) and EBREAK (halt), drives the
//                execute unit and register-file ports, advances the PC,
//                counts retired instructions, and halts on EBREAK, an
//                unsupported instruction or a fetch timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          core clock, synchronous active-high reset
//    imem_req/addr     fetch request (FETCH only) and fetch address (= pc)
//    imem_rdata/rvalid instruction word and its valid strobe
//    rf_raddr/rdata    rs1 read port (combinational regfile)
//    rf_wen/waddr/wdata  rd write port, one-cycle strobe in WB
//    ex_op/funct3/imm/src1  operands to the execute unit
//    ex_result         execute unit result (combinational)
//    pc, instret       PC of the instruction in flight, retired count
//    halt/illegal/fetch_err  sticky halt status and cause flags
// ============================================================================
module npc_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    // register file
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    // execute unit
    output logic [6:0]  ex_op,
    output logic [2:0]  ex_funct3,
    output logic [11:0] ex_imm,
    output logic [31:0] ex_src1,
    input  logic [31:0] ex_result,
    // status
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halt,
    output logic        illegal,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [6:0]  c_OP_IMM   = 7'b0010011;
    localparam logic [2:0]  c_F3_ADDI  = 3'b000;
    localparam logic [31:0] c_EBREAK   = 32'h0010_0073;
    // The wait counter holds the number of rvalid-less FETCH cycles already
    // completed, so the timeout fires while it equals FETCH_TIMEOUT-1.
    localparam logic [15:0] c_WAIT_LAST = 16'(FETCH_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_src1;
    logic [31:0] r_res;
    logic [31:0] r_instret;
    logic [15:0] r_wait_cnt;
    logic        r_halt;
    logic        r_illegal;
    logic        r_fetch_err;
    logic        r_imem_req;
    logic        r_rf_wen;

    logic        w_is_addi;
    logic        w_is_ebreak;
    logic        w_rd_nonzero;

    assign w_is_addi    = (r_ir[6:0] == c_OP_IMM) && (r_ir[14:12] == c_F3_ADDI);
    assign w_is_ebreak  = (r_ir == c_EBREAK);
    assign w_rd_nonzero = (r_ir[11:7] != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_ir        <= 32'd0;
            r_src1      <= 32'd0;
            r_res       <= 32'd0;
            r_instret   <= 32'd0;
            r_wait_cnt  <= 16'd0;
            r_halt      <= 1'b0;
            r_illegal   <= 1'b0;
            r_fetch_err <= 1'b0;
            r_imem_req  <= 1'b1;
            r_rf_wen    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_rvalid) begin
                        r_ir       <= imem_rdata;
                        r_wait_cnt <= 16'd0;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_halt      <= 1'b1;
                        r_imem_req  <= 1'b0;
                        r_state     <= S_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end

                S_DECODE: begin
                    r_src1 <= rf_rdata;
                    if (w_is_addi) begin
                        r_state <= S_EXEC;
                    end else if (w_is_ebreak) begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_illegal <= 1'b1;
                        r_halt    <= 1'b1;
                        r_state   <= S_HALT;
                    end
                end

                S_EXEC: begin
                    r_res    <= ex_result;
                    // Writes to x0 are dropped here so WB never strobes them.
                    r_rf_wen <= w_rd_nonzero;
                    r_state  <= S_WB;
                end

                S_WB: begin
                    r_rf_wen   <= 1'b0;
                    r_pc       <= r_pc + 32'd4;
                    r_instret  <= r_instret + 32'd1;
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end

                S_HALT: begin
                    // Absorbing: everything frozen until reset.
                end

                default: begin
                    // Unreachable encodings park the core safely.
                    r_halt     <= 1'b1;
                    r_imem_req <= 1'b0;
                    r_rf_wen   <= 1'b0;
                    r_state    <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;

    assign rf_raddr  = r_ir[19:15];
    assign rf_wen    = r_rf_wen;
    assign rf_waddr  = r_ir[11:7];
    assign rf_wdata  = r_res;

    assign ex_op     = r_ir[6:0];
    assign ex_funct3 = r_ir[14:12];
    assign ex_imm    = r_ir[31:20];
    assign ex_src1   = r_src1;

    assign pc        = r_pc;
    assign instret   = r_instret;
    assign halt      = r_halt;
    assign illegal   = r_illegal;
    assign fetch_err = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_npc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_ctrl
//  Description : Directed self-checking bench for npc_ctrl. The instruction
//                memory, register file read data and execute unit are small
//                bench-side models; expected values are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_ctrl;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [6:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic [11:0] ex_imm;
    logic [31:0] ex_src1;
    logic [31:0] ex_result;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halt;
    logic        illegal;
    logic        fetch_err;

    logic [31:0] mem_word;
    logic        mem_valid;
    logic [31:0] rf_val;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_req;
    int cnt_wen;

    always #5 clk = ~clk;

    assign imem_rdata  = mem_word;
    assign imem_rvalid = mem_valid;
    assign rf_rdata    = rf_val;
    // Execute-unit model: ADDI = src1 + sign-extended imm.
    assign ex_result   = ex_src1 + {{20{ex_imm[11]}}, ex_imm};

    npc_ctrl #(
        .RESET_PC      (c_RESET_PC),
        .FETCH_TIMEOUT (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .ex_op       (ex_op),
        .ex_funct3   (ex_funct3),
        .ex_imm      (ex_imm),
        .ex_src1     (ex_src1),
        .ex_result   (ex_result),
        .pc          (pc),
        .instret     (instret),
        .halt        (halt),
        .illegal     (illegal),
        .fetch_err   (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_word  = 32'd0;
        rf_val    = 32'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_word  = 32'd0;
        rf_val    = 32'd0;
        tick();
        tick();
        // ---- reset state ----
        check("rst_req",      32'(imem_req),  32'd1);
        check("rst_pc",       pc,             c_RESET_PC);
        check("rst_addr",     imem_addr,      c_RESET_PC);
        check("rst_instret",  instret,        32'd0);
        check("rst_halt",     32'(halt),      32'd0);
        check("rst_illegal",  32'(illegal),   32'd0);
        check("rst_fetcherr", 32'(fetch_err), 32'd0);
        check("rst_wen",      32'(rf_wen),    32'd0);
        rst = 1'b0;

        // ---- 1: addi x1,x0,5 with rvalid in the first FETCH cycle ----
        mem_word  = 32'h0050_0093;
        mem_valid = 1'b1;
        rf_val    = 32'd0;
        check("t1_wen_c1", 32'(rf_wen), 32'd0);
        tick();
        check("t1_wen_c2", 32'(rf_wen), 32'd0);
        tick();
        check("t1_wen_c3", 32'(rf_wen), 32'd0);
        check("t1_ex_op",  32'(ex_op),     32'h13);
        check("t1_ex_f3",  32'(ex_funct3), 32'd0);
        check("t1_ex_imm", 32'(ex_imm),    32'd5);
        check("t1_ex_src", ex_src1,        32'd0);
        tick();
        check("t1_wen_c4", 32'(rf_wen),   32'd1);
        check("t1_waddr",  32'(rf_waddr), 32'd1);
        check("t1_wdata",  rf_wdata,      32'd5);
        check("t1_req_wb", 32'(imem_req), 32'd0);
        tick();
        check("t1_wen_c5",   32'(rf_wen),   32'd0);
        check("t1_pc",       pc,            32'h8000_0004);
        check("t1_instret",  instret,       32'd1);
        check("t1_req_next", 32'(imem_req), 32'd1);

        // ---- 2: addi x0,x1,7 -- no x0 write, pc and instret advance ----
        mem_word = 32'h0070_8013;
        rf_val   = 32'd3;
        cnt_wen  = 0;
        tick();
        check("t2_raddr", 32'(rf_raddr), 32'd1);
        if (rf_wen) cnt_wen++;
        tick();
        check("t2_ex_src", ex_src1, 32'd3);
        if (rf_wen) cnt_wen++;
        tick();
        check("t2_wdata", rf_wdata, 32'd10);
        if (rf_wen) cnt_wen++;
        tick();
        if (rf_wen) cnt_wen++;
        check("t2_no_wen",  32'(cnt_wen), 32'd0);
        check("t2_pc",      pc,           32'h8000_0008);
        check("t2_instret", instret,      32'd2);

        // ---- 6: reset during EXEC drops the pending write ----
        mem_word = 32'h0050_0093;
        rf_val   = 32'd0;
        tick();
        tick();
        check("t6_in_exec_wen", 32'(rf_wen), 32'd0);
        rst       = 1'b1;
        mem_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_wen",     32'(rf_wen),   32'd0);
        check("t6_req",     32'(imem_req), 32'd1);
        check("t6_pc",      pc,            c_RESET_PC);
        check("t6_instret", instret,       32'd0);
        tick();
        check("t6_wen_after", 32'(rf_wen), 32'd0);

        // ---- 3: EBREAK after one ADDI halts cleanly ----
        do_reset();
        mem_word  = 32'h0090_0113;
        mem_valid = 1'b1;
        repeat (4) tick();
        mem_word = 32'h0010_0073;
        tick();
        check("t3_halt_decode", 32'(halt), 32'd0);
        tick();
        check("t3_halt",     32'(halt),      32'd1);
        check("t3_illegal",  32'(illegal),   32'd0);
        check("t3_fetcherr", 32'(fetch_err), 32'd0);
        check("t3_pc",       pc,             32'h8000_0004);
        check("t3_instret",  instret,        32'd1);
        mem_word = 32'h0050_0093;
        cnt_req  = 0;
        cnt_wen  = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) cnt_req++;
            if (rf_wen)   cnt_wen++;
            tick();
        end
        check("t3_req_stays0", 32'(cnt_req), 32'd0);
        check("t3_no_wen",     32'(cnt_wen), 32'd0);
        check("t3_pc_frozen",  pc,           32'h8000_0004);

        // ---- 4: unsupported instruction, later rvalid ignored ----
        do_reset();
        mem_word  = 32'h0000_0033;
        mem_valid = 1'b1;
        tick();
        tick();
        check("t4_illegal",  32'(illegal),   32'd1);
        check("t4_halt",     32'(halt),      32'd1);
        check("t4_fetcherr", 32'(fetch_err), 32'd0);
        mem_word = 32'h0050_0093;
        cnt_req  = 0;
        cnt_wen  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (imem_req) cnt_req++;
            if (rf_wen)   cnt_wen++;
        end
        check("t4_req",     32'(cnt_req), 32'd0);
        check("t4_wen",     32'(cnt_wen), 32'd0);
        check("t4_pc",      pc,           c_RESET_PC);
        check("t4_instret", instret,      32'd0);
        check("t4_halt_kept", 32'(halt),  32'd1);

        // ---- 5: fetch timeout after the 4th wait cycle ----
        do_reset();
        repeat (3) tick();
        check("t5_halt_w3", 32'(halt),     32'd0);
        check("t5_req_w3",  32'(imem_req), 32'd1);
        tick();
        check("t5_halt",     32'(halt),      32'd1);
        check("t5_fetcherr", 32'(fetch_err), 32'd1);
        check("t5_illegal",  32'(illegal),   32'd0);
        check("t5_req",      32'(imem_req),  32'd0);

        // ---- 5b: rvalid in the last allowed cycle; counter clears ----
        do_reset();
        repeat (3) tick();
        mem_word  = 32'h0050_0093;
        mem_valid = 1'b1;
        tick();
        check("t5b_halt_late", 32'(halt),      32'd0);
        check("t5b_err_late",  32'(fetch_err), 32'd0);
        mem_valid = 1'b0;
        repeat (3) tick();
        check("t5b_pc", pc, 32'h8000_0004);
        repeat (3) tick();
        mem_valid = 1'b1;
        tick();
        check("t5b_halt_2nd", 32'(halt),      32'd0);
        check("t5b_err_2nd",  32'(fetch_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
